// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Holds the FSM state encoding, the sequential PC increment and the
// instruction-alignment mask, plus a helper that tests redirect alignment.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    RESET_S,
    ISSUE,
    FETCH,
    DELIVER,
    DRAIN,
    FAULT
  } fetch_state_t;

  localparam int         PC_STEP    = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // A redirect target is usable only if it is word aligned.
  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Purpose: fetch performance counters (instructions consumed, stalled cycles).
// Latency: counters reflect an event one cycle after it is signalled.
// Backpressure: none; pure event counters that wrap modulo 2^PERF_W.
// Ports: clk/rst (sync, active-high); i_fetch_inc, i_stall_inc event strobes;
//        o_fetched, o_stall counter values.
// Only compiled when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_ctr
  import fetch_sequencer_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch_inc,
  input  logic              i_stall_inc,
  output logic [PERF_W-1:0] o_fetched,
  output logic [PERF_W-1:0] o_stall
);

  logic [PERF_W-1:0] r_fetched;
  logic [PERF_W-1:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetched <= '0;
      r_stall   <= '0;
    end else begin
      if (i_fetch_inc) r_fetched <= r_fetched + 1'b1;
      if (i_stall_inc) r_stall   <= r_stall + 1'b1;
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Purpose: PC/fetch controller for the multicycle RISC-V core.
// Latency: 3 cycles per instruction minimum (ISSUE, FETCH w/ immediate resp, DELIVER).
// Backpressure: stall holds the delivered instruction in DELIVER; no new read is issued.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_q / pc_load / pc_next PC register read-back, load enable, data_in
//   imem_*                   instruction read request/address, one-cycle resp + rdata
//   redirect_valid/_target   taken branch/jump
//   stall                    decode not ready
//   instr_valid/instr/instr_pc  delivered instruction
//   fetch_fault              sticky misaligned-redirect trap
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_stall counter ports.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_q,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  // Counter word type; only instantiated when the perf counters are built.
  typedef logic [PERF_W-1:0] perf_cnt_t;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;

  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_instr_valid;
  logic            r_fault_pending;

  logic            w_aligned;
  logic            w_load_req;
  logic            w_capture;
  logic            w_clear_valid;
  logic            w_set_fault;

  assign w_aligned = is_aligned(redirect_target[1:0]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RESET_S;
    else     r_state <= w_state_nxt;
  end

  // Next state and combinational outputs.
  always_comb begin
    w_state_nxt   = r_state;
    pc_load       = 1'b0;
    pc_next       = '0;
    imem_read     = 1'b0;
    fetch_fault   = 1'b0;
    w_load_req    = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = 1'b0;
    w_set_fault   = 1'b0;

    // Redirect PC update is shared by ISSUE/FETCH/DELIVER/DRAIN; only the
    // next-state choice differs per state.
    if (redirect_valid && r_state != RESET_S && r_state != FAULT) begin
      pc_load     = w_aligned;
      pc_next     = redirect_target;
      w_set_fault = ~w_aligned;
    end

    case (r_state)
      RESET_S: begin
        w_state_nxt = ISSUE;
      end

      ISSUE: begin
        if (redirect_valid) begin
          // Aligned: stay and latch the new PC next cycle.
          if (!w_aligned) w_state_nxt = FAULT;
        end else begin
          w_load_req  = 1'b1;
          w_state_nxt = FETCH;
        end
      end

      FETCH: begin
        imem_read = 1'b1;
        if (redirect_valid) begin
          if (imem_resp) w_state_nxt = w_aligned ? ISSUE : FAULT;
          else           w_state_nxt = DRAIN;
        end else if (imem_resp) begin
          w_capture   = 1'b1;
          pc_load     = 1'b1;
          pc_next     = r_req_addr + XLEN'(PC_STEP);
          w_state_nxt = DELIVER;
        end
      end

      DELIVER: begin
        if (redirect_valid) begin
          // Redirect wins over consumption: the held instruction is dropped.
          w_clear_valid = 1'b1;
          w_state_nxt   = w_aligned ? ISSUE : FAULT;
        end else if (!stall) begin
          w_clear_valid = 1'b1;
          w_state_nxt   = ISSUE;
        end
      end

      DRAIN: begin
        // Keep the abandoned read alive until memory completes it. A redirect
        // that lands on the completing cycle still updates the PC, and its
        // fault (if any) is folded into the exit decision.
        imem_read = 1'b1;
        if (imem_resp)
          w_state_nxt = (r_fault_pending || w_set_fault) ? FAULT : ISSUE;
      end

      FAULT: begin
        fetch_fault = 1'b1;
      end

      default: begin
        w_state_nxt = RESET_S;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr      <= '0;
      r_instr         <= '0;
      r_instr_pc      <= '0;
      r_instr_valid   <= 1'b0;
      r_fault_pending <= 1'b0;
    end else begin
      if (w_load_req) r_req_addr <= pc_q;
      if (w_capture) begin
        r_instr       <= imem_rdata;
        r_instr_pc    <= r_req_addr;
        r_instr_valid <= 1'b1;
      end else if (w_clear_valid) begin
        r_instr_valid <= 1'b0;
      end
      // Sticky until reset; a later aligned redirect does not clear it.
      if (w_set_fault) r_fault_pending <= 1'b1;
    end
  end

  assign imem_address = r_req_addr;
  assign instr_valid  = r_instr_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;

`ifdef FETCH_PERF_EN
  logic      w_consume;
  logic      w_stall_cyc;
  perf_cnt_t w_perf_fetched;
  perf_cnt_t w_perf_stall;

  assign w_consume   = (r_state == DELIVER) && !stall && !redirect_valid;
  assign w_stall_cyc = (r_state == DELIVER) && stall;

  fetch_perf_ctr #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_fetch_inc (w_consume),
    .i_stall_inc (w_stall_cyc),
    .o_fetched   (w_perf_fetched),
    .o_stall     (w_perf_stall)
  );

  assign perf_fetched = w_perf_fetched;
  assign perf_stall   = w_perf_stall;
`endif

endmodule
